ex_muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit in the EX stage, beside the single-cycle ALU.

---
 rtl/ex_muldiv_unit.sv | 171 +++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
//------------------------------------------------------------------------------
// Module   : ex_muldiv_unit
// Brief    : Iterative RV32M multiply/divide unit (radix-2 shift-add / restoring).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ex_muldiv_unit #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [2:0]      Op,
    input  logic [XLEN-1:0] Op1,
    input  logic [XLEN-1:0] Op2,
    input  logic [RD_W-1:0] Rd_addr_in,
    input  logic            Flush,
    output logic            Busy,
    output logic            Stall,
    output logic            Done,
    output logic [XLEN-1:0] Result,
    output logic [RD_W-1:0] Rd_addr_out
);

    localparam int              CNT_W     = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FAST = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   a_q, a_d;        // multiplicand / divisor magnitude
    logic [XLEN-1:0]   hi_q, hi_d;      // product high half / partial remainder
    logic [XLEN-1:0]   lo_q, lo_d;      // multiplier->product low / dividend->quotient
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic [RD_W-1:0]   rdo_q, rdo_d;

    logic              w_s1, w_s2, w_div0, w_ovf;
    logic [XLEN-1:0]   w_mag1, w_mag2;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_sh;
    logic [XLEN-1:0]   w_div_diff;
    logic              w_div_ge;
    logic [2*XLEN-1:0] w_wide, w_wide_s;
    logic [XLEN-1:0]   w_res;

    assign w_s1   = ((Op == 3'd1) | (Op == 3'd2) | (Op[2] & ~Op[0])) & Op1[XLEN-1];
    assign w_s2   = ((Op == 3'd1) | (Op[2] & ~Op[0])) & Op2[XLEN-1];
    assign w_mag1 = w_s1 ? -Op1 : Op1;
    assign w_mag2 = w_s2 ? -Op2 : Op2;
    assign w_div0 = Op[2] & (Op2 == '0);
    assign w_ovf  = Op[2] & ~Op[0] & (Op1 == INT_MIN) & (&Op2);

    assign w_mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
    assign w_div_sh   = {hi_q, lo_q[XLEN-1]};
    assign w_div_ge   = (w_div_sh >= {1'b0, a_q});
    assign w_div_diff = w_div_sh[XLEN-1:0] - a_q;

    // Full-width negation so the MULH* high half carries correctly from the low half.
    assign w_wide   = op_q[2] ? {{XLEN{1'b0}}, (op_q[1] ? hi_q : lo_q)} : {hi_q, lo_q};
    assign w_wide_s = neg_q ? -w_wide : w_wide;
    assign w_res    = (op_q[2] || (op_q[1:0] == 2'b00)) ? w_wide_s[XLEN-1:0]
                                                        : w_wide_s[2*XLEN-1:XLEN];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_d   = neg_q;
        a_d     = a_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        res_d   = res_q;
        rdo_d   = rdo_q;
        if (Flush && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Start && !Flush) begin
                        op_d  = Op;
                        rd_d  = Rd_addr_in;
                        cnt_d = '0;
                        if (w_div0 || w_ovf) begin
                            state_d = S_FAST;
                            neg_d   = 1'b0;
                            a_d     = '0;
                            hi_d    = w_div0 ? Op1 : '0;
                            lo_d    = w_div0 ? '1 : Op1;
                        end else begin
                            state_d = Op[2] ? S_DIV : S_MUL;
                            neg_d   = (Op[2] & Op[1]) ? w_s1 : (w_s1 ^ w_s2);
                            a_d     = w_mag2;
                            hi_d    = '0;
                            lo_d    = w_mag1;
                        end
                    end
                end
                S_MUL: begin
                    hi_d  = w_mul_sum[XLEN:1];
                    lo_d  = {w_mul_sum[0], lo_q[XLEN-1:1]};
                    cnt_d = cnt_q + ONE_C;
                    if (cnt_q == LAST_STEP) state_d = S_FIN;
                end
                S_DIV: begin
                    hi_d  = w_div_ge ? w_div_diff : w_div_sh[XLEN-1:0];
                    lo_d  = {lo_q[XLEN-2:0], w_div_ge};
                    cnt_d = cnt_q + ONE_C;
                    if (cnt_q == LAST_STEP) state_d = S_FIN;
                end
                S_FAST: state_d = S_FIN;
                S_FIN: begin
                    state_d = S_IDLE;
                    res_d   = w_res;
                    rdo_d   = rd_q;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            neg_q   <= 1'b0;
            a_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            res_q   <= '0;
            rdo_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            a_q     <= a_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
            rdo_q   <= rdo_d;
        end
    end

    // Result is visible during the Done cycle itself; the held copy updates on that edge.
    assign Busy        = (state_q != S_IDLE);
    assign Done        = (state_q == S_FIN) & ~Flush;
    assign Result      = Done ? w_res : res_q;
    assign Rd_addr_out = Done ? rd_q : rdo_q;
    assign Stall       = (Start & (state_q == S_IDLE) & ~Flush) | (Busy & ~Done);

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_ex_muldiv_unit
// Brief    : Directed self-checking bench for ex_muldiv_unit.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ex_muldiv_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [2:0]  Op = '0;
    logic [31:0] Op1 = '0;
    logic [31:0] Op2 = '0;
    logic [4:0]  Rd_addr_in = '0;
    logic        Flush = 1'b0;
    logic        Busy, Stall, Done;
    logic [31:0] Result;
    logic [4:0]  Rd_addr_out;

    int total = 0;
    int bad   = 0;

    ex_muldiv_unit #(.XLEN(32), .RD_W(5)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .Op1(Op1), .Op2(Op2),
        .Rd_addr_in(Rd_addr_in), .Flush(Flush), .Busy(Busy), .Stall(Stall),
        .Done(Done), .Result(Result), .Rd_addr_out(Rd_addr_out)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        bit seen;
        Start = 1'b1; Op = op; Op1 = a; Op2 = b; Rd_addr_in = rd;
        #1;
        chk({tag, ".stall_c0"}, Stall, 1);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            tick();
            Start = 1'b0;
            lat++;
            if (Done) seen = 1'b1;
        end
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".result"}, Result, exp);
        chk({tag, ".rd"}, Rd_addr_out, rd);
        chk({tag, ".stall_done"}, Stall, 0);
        chk({tag, ".busy_done"}, Busy, 1);
        tick();
        chk({tag, ".done_after"}, Done, 0);
        chk({tag, ".busy_after"}, Busy, 0);
        chk({tag, ".result_held"}, Result, exp);
    endtask

    initial begin
        int dcount, dcyc;
        logic [31:0] dres;
        logic [4:0]  drd;

        tick();
        tick();
        Reset = 1'b0;
        #1;
        chk("reset.busy", Busy, 0);
        chk("reset.done", Done, 0);
        chk("reset.result", Result, 0);
        chk("reset.rd", Rd_addr_out, 0);
        chk("reset.stall", Stall, 0);

        run_op("mul_7x6",     3'd0, 32'd7,        32'd6,        5'd3,  32'h0000002A, 33);
        run_op("mulhu_ff",    3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE, 33);
        run_op("mulh_ff",     3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'h00000000, 33);
        run_op("mulhsu",      3'd2, 32'hFFFFFFFF, 32'h00000002, 5'd6,  32'hFFFFFFFF, 33);
        run_op("div_m7_2",    3'd4, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, 33);
        run_op("rem_m7_2",    3'd6, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, 33);
        run_op("divu_100_7",  3'd5, 32'd100,      32'd7,        5'd10, 32'd14,       33);
        run_op("remu_100_7",  3'd7, 32'd100,      32'd7,        5'd11, 32'd2,        33);
        run_op("divu_div0",   3'd5, 32'd5,        32'd0,        5'd12, 32'hFFFFFFFF, 2);
        run_op("rem_div0",    3'd6, 32'd5,        32'd0,        5'd13, 32'd5,        2);
        run_op("rem_neg_div0",3'd6, 32'hFFFFFFF9, 32'd0,        5'd14, 32'hFFFFFFF9, 2);
        run_op("div_ovf",     3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 2);
        run_op("rem_ovf",     3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h00000000, 2);
        run_op("mul_m3x5",    3'd0, 32'hFFFFFFFD, 32'd5,        5'd9,  32'hFFFFFFF1, 33);

        // Flush an in-flight multiply at cycle 10.
        Start = 1'b1; Op = 3'd0; Op1 = 32'd3; Op2 = 32'd3; Rd_addr_in = 5'd20;
        tick();
        Start = 1'b0;
        dcount = int'(Done);
        repeat (9) begin
            tick();
            dcount += int'(Done);
        end
        Flush = 1'b1;
        #1;
        dcount += int'(Done);
        chk("flush.no_done", dcount, 0);
        chk("flush.busy_c10", Busy, 1);
        tick();
        Flush = 1'b0;
        #1;
        chk("flush.busy_c11", Busy, 0);
        chk("flush.done_c11", Done, 0);
        chk("flush.result_kept", Result, 32'hFFFFFFF1);
        chk("flush.rd_kept", Rd_addr_out, 9);
        run_op("mul_after_flush", 3'd0, 32'd9, 32'd9, 5'd21, 32'd81, 33);

        // Start held high with different operands while busy must be ignored.
        Start = 1'b1; Op = 3'd0; Op1 = 32'd5; Op2 = 32'd5; Rd_addr_in = 5'd7;
        tick();
        dcount = 0; dcyc = 0; dres = '0; drd = '0;
        for (int c = 1; c <= 40; c++) begin
            if (c >= 5 && c <= 20) begin
                Start = 1'b1; Op = 3'd5; Op1 = 32'd123; Op2 = 32'd4; Rd_addr_in = 5'd1;
            end else begin
                Start = 1'b0;
            end
            #1;
            if (Done) begin
                dcount++;
                dcyc = c;
                dres = Result;
                drd  = Rd_addr_out;
            end
            tick();
        end
        chk("ignore.done_count", dcount, 1);
        chk("ignore.done_cycle", dcyc, 33);
        chk("ignore.result", dres, 32'd25);
        chk("ignore.rd", drd, 7);
        chk("ignore.idle_after", Busy, 0);

        // Reset in the middle of a divide.
        Start = 1'b1; Op = 3'd5; Op1 = 32'd1000; Op2 = 32'd3; Rd_addr_in = 5'd4;
        tick();
        Start = 1'b0;
        repeat (14) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        #1;
        chk("midrst.busy", Busy, 0);
        chk("midrst.done", Done, 0);
        chk("midrst.result", Result, 0);
        chk("midrst.rd", Rd_addr_out, 0);
        chk("midrst.stall", Stall, 0);
        dcount = 0;
        repeat (40) begin
            tick();
            dcount += int'(Done);
        end
        chk("midrst.no_done", dcount, 0);
        run_op("divu_after_rst", 3'd5, 32'd100, 32'd7, 5'd2, 32'd14, 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
